// File: rtl/temp_ascii_framer.sv
// temp_ascii_framer: converts a signed 0.0001 degC magnitude into a
// fixed-width ASCII line and streams it byte by byte over valid/ready.
module temp_ascii_framer #(
  parameter bit EOL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        temp_sign,
  input  logic [23:0] temp_out,
  input  logic        temp_out_vld,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        busy
);

  localparam logic [3:0] LAST = EOL_EN ? 4'd10 : 4'd8;
  localparam logic [23:0] MAX_MAG = 24'd9999999;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SEND
  } state_t;

  state_t state, state_nxt;

  logic        pend_vld;
  logic        pend_sign;
  logic [23:0] pend_mag;

  logic        neg;
  logic        sat;
  logic [23:0] bin;
  logic [27:0] bcd;
  logic [4:0]  cnt;
  logic [3:0]  idx;

  logic        load;
  logic        ld_pend;
  logic        conv_done;
  logic        xfer;
  logic        ld_sign;
  logic [23:0] ld_mag;

  logic [27:0] bcd_adj;
  logic [51:0] dd_full;
  logic [3:0]  idx_n;
  logic [3:0]  dig_raw;
  logic [3:0]  dig;
  logic [7:0]  next_byte;

  assign busy      = (state != IDLE);
  assign xfer      = tx_vld & tx_rdy;
  assign conv_done = (state == CONV) && (cnt == 5'd23);
  assign ld_sign   = ld_pend ? pend_sign : temp_sign;
  assign ld_mag    = ld_pend ? pend_mag : temp_out;
  assign idx_n     = idx + 4'd1;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ld_pend   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_vld) begin
          load      = 1'b1;
          ld_pend   = 1'b1;
          state_nxt = CONV;
        end else if (temp_out_vld) begin
          load      = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (cnt == 5'd23) state_nxt = SEND;
      end
      SEND: begin
        if (xfer && idx == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // One-deep buffer: a strobe that cannot load directly always lands here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_sign <= 1'b0;
      pend_mag  <= '0;
    end else if (temp_out_vld && (state != IDLE || ld_pend)) begin
      pend_vld  <= 1'b1;
      pend_sign <= temp_sign;
      pend_mag  <= temp_out;
    end else if (ld_pend) begin
      pend_vld  <= 1'b0;
    end
  end

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 7; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = bcd[4*i +: 4];
    end
    dd_full = {bcd_adj, bin} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg <= 1'b0;
      sat <= 1'b0;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (load) begin
      neg <= ld_sign & (|ld_mag);
      sat <= (ld_mag > MAX_MAG);
      bin <= ld_mag;
      bcd <= '0;
      cnt <= '0;
    end else if (state == CONV) begin
      bcd <= dd_full[51:24];
      bin <= dd_full[23:0];
      cnt <= cnt + 5'd1;
    end
  end

  always_comb begin
    dig_raw   = 4'd0;
    next_byte = 8'h00;
    case (idx_n)
      4'd1:    dig_raw = bcd[27:24];
      4'd2:    dig_raw = bcd[23:20];
      4'd3:    dig_raw = bcd[19:16];
      4'd5:    dig_raw = bcd[15:12];
      4'd6:    dig_raw = bcd[11:8];
      4'd7:    dig_raw = bcd[7:4];
      4'd8:    dig_raw = bcd[3:0];
      default: dig_raw = 4'd0;
    endcase
    dig = sat ? 4'd9 : dig_raw;
    case (idx_n)
      4'd4:    next_byte = 8'h2E;
      4'd9:    next_byte = 8'h0D;
      4'd10:   next_byte = 8'h0A;
      default: next_byte = {4'h3, dig};
    endcase
  end

  // The sign byte is ready as the last shift lands; digits follow from final BCD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_vld  <= 1'b0;
      tx_data <= 8'h00;
      idx     <= '0;
    end else if (conv_done) begin
      tx_vld  <= 1'b1;
      tx_data <= neg ? 8'h2D : 8'h2B;
      idx     <= '0;
    end else if (xfer) begin
      if (idx == LAST) begin
        tx_vld <= 1'b0;
      end else begin
        idx     <= idx_n;
        tx_data <= next_byte;
      end
    end
  end

endmodule

// File: tb/tb_temp_ascii_framer.sv
// tb_temp_ascii_framer: randomized self-checking bench with an arithmetic
// reference model of the ASCII frame.
module tb_temp_ascii_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        temp_sign = 1'b0;
  logic [23:0] temp_out = '0;
  logic        temp_out_vld = 1'b0;
  logic        temp_out_vld0 = 1'b0;
  logic        tx_rdy = 1'b1;
  logic        tx_rdy0 = 1'b1;
  logic [7:0]  tx_data, tx_data0;
  logic        tx_vld, tx_vld0;
  logic        busy, busy0;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx[$];
  logic [7:0] rx0[$];
  int         stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  temp_ascii_framer #(.EOL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .temp_sign(temp_sign), .temp_out(temp_out),
    .temp_out_vld(temp_out_vld),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .busy(busy)
  );

  temp_ascii_framer #(.EOL_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .temp_sign(temp_sign), .temp_out(temp_out),
    .temp_out_vld(temp_out_vld0),
    .tx_data(tx_data0), .tx_vld(tx_vld0), .tx_rdy(tx_rdy0),
    .busy(busy0)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (prev_stall && (!tx_vld || tx_data !== prev_data))
        stall_viol <= stall_viol + 1;
      if (tx_vld && tx_rdy) rx.push_back(tx_data);
      if (tx_vld0 && tx_rdy0) rx0.push_back(tx_data0);
      prev_stall <= tx_vld && !tx_rdy;
      prev_data  <= tx_data;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  function automatic logic [87:0] model(bit s, int unsigned mag, bit eol);
    logic [7:0]  b[11];
    logic [87:0] v;
    int unsigned m, ip, fp;
    v = '0;
    m = (mag > 9999999) ? 9999999 : mag;
    ip = m / 10000;
    fp = m % 10000;
    b[0]  = (mag == 0 || !s) ? 8'h2B : 8'h2D;
    b[1]  = 8'(48 + ip / 100);
    b[2]  = 8'(48 + (ip / 10) % 10);
    b[3]  = 8'(48 + ip % 10);
    b[4]  = 8'h2E;
    b[5]  = 8'(48 + fp / 1000);
    b[6]  = 8'(48 + (fp / 100) % 10);
    b[7]  = 8'(48 + (fp / 10) % 10);
    b[8]  = 8'(48 + fp % 10);
    b[9]  = 8'h0D;
    b[10] = 8'h0A;
    for (int i = 0; i < (eol ? 11 : 9); i++) v = {v[79:0], b[i]};
    return v;
  endfunction

  function automatic logic [87:0] pack_rx(int off, int n);
    logic [87:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      v = {v[79:0], (off + i < rx.size()) ? rx[off + i] : 8'h00};
    return v;
  endfunction

  function automatic logic [87:0] pack_rx0(int n);
    logic [87:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      v = {v[79:0], (i < rx0.size()) ? rx0[i] : 8'h00};
    return v;
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(bit s, int unsigned m);
    @(negedge clk);
    temp_sign = s;
    temp_out = m[23:0];
    temp_out_vld = 1'b1;
    @(negedge clk);
    temp_out_vld = 1'b0;
  endtask

  task automatic wait_bytes(int n, int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (rx.size() >= n) break;
      @(negedge clk);
    end
    ok = (rx.size() >= n);
  endtask

  task automatic wait_txvld(int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (tx_vld) break;
      @(negedge clk);
    end
    ok = tx_vld;
  endtask

  task automatic run_one(bit s, int unsigned m, output logic [87:0] got,
                         output bit ok);
    rx.delete();
    strobe(s, m);
    wait_bytes(11, 200, ok);
    got = pack_rx(0, 11);
    tick(3);
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if (tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx_data got %h exp 00", tx_data);
    end
    checks++;
    if (tx_vld !== 1'b0 || tx_vld0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx_vld got %b/%b exp 0", tx_vld, tx_vld0);
    end
    checks++;
    if (busy !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b/%b exp 0", busy, busy0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_positive;
    int lat;
    bit ok;
    logic [87:0] got;
    rx.delete();
    lat = 0;
    @(negedge clk);
    temp_sign = 1'b0;
    temp_out = 24'd253750;
    temp_out_vld = 1'b1;
    @(posedge clk);
    #1 temp_out_vld = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (tx_vld) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 24) begin
      errors++;
      $display("FAIL pos_latency got %0d exp 24", lat);
    end
    wait_bytes(11, 100, ok);
    got = pack_rx(0, 11);
    checks++;
    if (!ok || got !== 88'h2B3032352E333735300D0A) begin
      errors++;
      $display("FAIL pos_frame got %h exp 2B3032352E333735300D0A", got);
    end
    tick(3);
  endtask

  task automatic test_fixed;
    bit ok;
    logic [87:0] got, exp;
    run_one(1'b1, 100625, got, ok);
    checks++;
    if (!ok || got !== 88'h2D3031302E303632350D0A) begin
      errors++;
      $display("FAIL neg_frame got %h exp 2D3031302E303632350D0A", got);
    end
    run_one(1'b1, 0, got, ok);
    exp = model(1'b1, 0, 1'b1);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL zero_frame got %h exp %h", got, exp);
    end
    run_one(1'b0, 32'hFFFFFF, got, ok);
    exp = model(1'b0, 32'hFFFFFF, 1'b1);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL sat_frame got %h exp %h", got, exp);
    end
    run_one(1'b0, 10000000, got, ok);
    exp = model(1'b0, 10000000, 1'b1);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL sat_edge_frame got %h exp %h", got, exp);
    end
    run_one(1'b1, 9999999, got, ok);
    exp = model(1'b1, 9999999, 1'b1);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL max_frame got %h exp %h", got, exp);
    end
  endtask

  task automatic test_random;
    bit ok;
    bit s;
    int unsigned m;
    logic [87:0] got, exp;
    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) m = $urandom & 32'hFFFFFF;
      else m = $urandom_range(0, 9999999);
      run_one(s, m, got, ok);
      exp = model(s, m, 1'b1);
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL rand_frame[%0d] s=%0d m=%0d got %h exp %h",
                 i, s, m, got, exp);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    bit s;
    int unsigned m;
    int base, cyc, len;
    logic [87:0] got, exp;
    for (int f = 0; f < 3; f++) begin
      rx.delete();
      base = stall_viol;
      s = 1'($urandom_range(0, 1));
      m = $urandom_range(0, 9999999);
      strobe(s, m);
      wait_txvld(60, ok);
      tx_rdy = 1'b0;
      tick(200);
      cyc = 0;
      while (rx.size() < 11 && cyc < 20000) begin
        if ($urandom_range(0, 3) == 0) begin
          tx_rdy = 1'b0;
          len = $urandom_range(1, 200);
        end else begin
          tx_rdy = 1'b1;
          len = $urandom_range(1, 3);
        end
        tick(len);
        cyc += len;
      end
      tx_rdy = 1'b1;
      tick(3);
      got = pack_rx(0, 11);
      exp = model(s, m, 1'b1);
      checks++;
      if (!ok || rx.size() != 11 || got !== exp) begin
        errors++;
        $display("FAIL bp_frame[%0d] n=%0d got %h exp %h",
                 f, rx.size(), got, exp);
      end
      checks++;
      if (stall_viol != base) begin
        errors++;
        $display("FAIL bp_stable[%0d] got %0d violations exp 0",
                 f, stall_viol - base);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    int unsigned mx, my;
    logic [87:0] got, exp;
    rx.delete();
    mx = $urandom_range(0, 9999999);
    my = $urandom_range(0, 9999999);
    strobe(1'b0, mx);
    wait_txvld(60, ok);
    n = 0;
    while (rx.size() < 10 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ok || n != 10) begin
      errors++;
      $display("FAIL b2b_rate got %0d cycles exp 10", n);
    end
    temp_sign = 1'b1;
    temp_out = my[23:0];
    temp_out_vld = 1'b1;
    @(negedge clk);
    temp_out_vld = 1'b0;
    checks++;
    if (rx.size() != 11 || tx_vld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got n=%0d vld=%b busy=%b exp 11/0/0",
               rx.size(), tx_vld, busy);
    end
    wait_bytes(22, 200, ok);
    got = pack_rx(11, 11);
    exp = model(1'b1, my, 1'b1);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL b2b_simul_frame got %h exp %h", got, exp);
    end
    tick(3);
  endtask

  task automatic test_pending;
    bit ok;
    int idle;
    int unsigned mx;
    logic [87:0] got, exp;
    rx.delete();
    mx = $urandom_range(0, 9999999);
    strobe(1'b0, mx);
    wait_txvld(60, ok);
    temp_sign = 1'b0;
    temp_out = 24'd1250000;
    temp_out_vld = 1'b1;
    @(negedge clk);
    temp_out_vld = 1'b0;
    tick(2);
    temp_out = 24'd550000;
    temp_out_vld = 1'b1;
    @(negedge clk);
    temp_out_vld = 1'b0;
    idle = 0;
    for (int i = 0; i < 300; i++) begin
      if (rx.size() >= 22) break;
      if (!busy) idle++;
      @(negedge clk);
    end
    tick(40);
    got = pack_rx(0, 11);
    exp = model(1'b0, mx, 1'b1);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL pend_first got %h exp %h", got, exp);
    end
    got = pack_rx(11, 11);
    checks++;
    if (rx.size() != 22 || got !== 88'h2B3035352E303030300D0A) begin
      errors++;
      $display("FAIL pend_second n=%0d got %h exp 2B3035352E303030300D0A",
               rx.size(), got);
    end
    checks++;
    if (idle != 1) begin
      errors++;
      $display("FAIL pend_idle got %0d idle cycles exp 1", idle);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int unsigned my;
    logic [87:0] got, exp;
    rx.delete();
    strobe(1'b1, $urandom_range(1, 9999999));
    wait_bytes(4, 100, ok);
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || tx_vld !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid got vld=%b busy=%b data=%h exp 0/0/00",
               tx_vld, busy, tx_data);
    end
    tick(3);
    rst_n = 1'b1;
    tick(2);
    my = $urandom_range(0, 9999999);
    run_one(1'b0, my, got, ok);
    tick(40);
    exp = model(1'b0, my, 1'b1);
    checks++;
    if (!ok || rx.size() != 11 || got !== exp) begin
      errors++;
      $display("FAIL rst_fresh_frame n=%0d got %h exp %h",
               rx.size(), got, exp);
    end
  endtask

  task automatic test_eol_off;
    int unsigned m;
    logic [87:0] got, exp;
    for (int f = 0; f < 2; f++) begin
      rx0.delete();
      m = (f == 0) ? 253750 : $urandom_range(0, 9999999);
      @(negedge clk);
      temp_sign = 1'(f);
      temp_out = m[23:0];
      temp_out_vld0 = 1'b1;
      @(negedge clk);
      temp_out_vld0 = 1'b0;
      tick(60);
      got = pack_rx0(9);
      exp = model(1'(f), m, 1'b0);
      checks++;
      if (rx0.size() != 9 || got !== exp || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL eol_off[%0d] n=%0d got %h exp %h", f,
                 rx0.size(), got, exp);
      end
    end
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_positive();
    test_fixed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_pending();
    test_reset_mid();
    test_eol_off();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
